mat_mult_seq: RTL and testbench

- Sequential N×N matrix multiply engine with start/done handshake.
- Computes C = A·B, or C += A·B in accumulate mode.
- Fetches operands from and writes results to a shared word memory through one request/grant port, one element per word, row-major.
- Sits behind the accelerator top as the parametrised successor of the combinational 2×2 multiplier.

---
 rtl/mat_mult_seq_if.sv | 23 ++
 rtl/mat_mult_seq.sv | 179 +++++++++++++++++
 tb/tb_mat_mult_seq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_mult_seq_if.sv
// Word-memory request/grant port shared by mat_mult_seq and its memory arbiter.
// One outstanding request; read data returns the cycle after a granted read.
interface mat_mult_seq_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int ACC_SIZE   = 18
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [ACC_SIZE-1:0]   mem_wdata;
    logic                  mem_gnt;
    logic [ACC_SIZE-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata
    );
endinterface

// File: rtl/mat_mult_seq.sv
// Sequential NxN matrix multiply, C = A*B or C += A*B, operating on a shared
// row-major word memory through a single request/grant port.
module mat_mult_seq #(
    parameter int DAT_SIZE   = 8,
    parameter int MAT_SIZE   = 4,
    parameter int ACC_SIZE   = 2*DAT_SIZE + $clog2(MAT_SIZE),
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  mode_acc,
    input  logic                  signed_mode,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [ADDR_WIDTH-1:0] base_c,
    output logic                  busy,
    output logic                  done,
    mat_mult_seq_if.master        mem
);

    localparam int CW = $clog2(MAT_SIZE);
    localparam logic [CW-1:0]         LAST = CW'(MAT_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] NA   = ADDR_WIDTH'(MAT_SIZE);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LD_C   = 4'd1;
    localparam logic [3:0] WT_C   = 4'd2;
    localparam logic [3:0] RD_A   = 4'd3;
    localparam logic [3:0] WT_A   = 4'd4;
    localparam logic [3:0] RD_B   = 4'd5;
    localparam logic [3:0] WT_B   = 4'd6;
    localparam logic [3:0] ST_C   = 4'd7;
    localparam logic [3:0] FINISH = 4'd8;

    logic [3:0]            state;
    logic [CW-1:0]         i, j, k;
    logic [ACC_SIZE-1:0]   acc;
    logic [DAT_SIZE-1:0]   a_op;
    logic [ADDR_WIDTH-1:0] ra, rb, rc;
    logic                  r_acc, r_sgn;

    logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c;
    logic [DAT_SIZE-1:0]   b_op;
    logic [2*DAT_SIZE-1:0] prod;
    logic [ACC_SIZE-1:0]   prod_ext;
    logic                  gnt_ok;

    always_comb begin
        addr_a = ra + ADDR_WIDTH'(i) * NA + ADDR_WIDTH'(k);
        addr_b = rb + ADDR_WIDTH'(k) * NA + ADDR_WIDTH'(j);
        addr_c = rc + ADDR_WIDTH'(i) * NA + ADDR_WIDTH'(j);
    end

    // Operands are widened to the full product width first so the multiply
    // is exact in both signed and unsigned interpretation.
    always_comb begin
        b_op = mem.mem_rdata[DAT_SIZE-1:0];
        if (r_sgn) begin
            prod     = $signed({{DAT_SIZE{a_op[DAT_SIZE-1]}}, a_op})
                     * $signed({{DAT_SIZE{b_op[DAT_SIZE-1]}}, b_op});
            prod_ext = ACC_SIZE'($signed(prod));
        end else begin
            prod     = {{DAT_SIZE{1'b0}}, a_op} * {{DAT_SIZE{1'b0}}, b_op};
            prod_ext = ACC_SIZE'(prod);
        end
    end

    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            LD_C: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = addr_c;
            end
            RD_A: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = addr_a;
            end
            RD_B: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = addr_b;
            end
            ST_C: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = addr_c;
                mem.mem_wdata = acc;
            end
            default: ;
        endcase
        busy   = (state != IDLE) && (state != FINISH);
        done   = (state == FINISH);
        gnt_ok = mem.mem_req & mem.mem_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            a_op  <= '0;
            ra    <= '0;
            rb    <= '0;
            rc    <= '0;
            r_acc <= 1'b0;
            r_sgn <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ra    <= base_a;
                    rb    <= base_b;
                    rc    <= base_c;
                    r_acc <= mode_acc;
                    r_sgn <= signed_mode;
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    acc   <= '0;
                    state <= mode_acc ? LD_C : RD_A;
                end
                LD_C: if (gnt_ok) state <= WT_C;
                WT_C: begin
                    acc   <= mem.mem_rdata;
                    state <= RD_A;
                end
                RD_A: if (gnt_ok) state <= WT_A;
                WT_A: begin
                    a_op  <= mem.mem_rdata[DAT_SIZE-1:0];
                    state <= RD_B;
                end
                RD_B: if (gnt_ok) state <= WT_B;
                WT_B: begin
                    acc <= acc + prod_ext;
                    if (k == LAST) begin
                        k     <= '0;
                        state <= ST_C;
                    end else begin
                        k     <= k + 1'b1;
                        state <= RD_A;
                    end
                end
                // acc is cleared on the store grant so the non-accumulating
                // path can go straight to the next RD_A without an extra cycle.
                ST_C: if (gnt_ok) begin
                    acc <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i     <= '0;
                            state <= FINISH;
                        end else begin
                            i     <= i + 1'b1;
                            state <= r_acc ? LD_C : RD_A;
                        end
                    end else begin
                        j     <= j + 1'b1;
                        state <= r_acc ? LD_C : RD_A;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: N=2 and N=4 instances on one shared
// word memory, checked against a plain-arithmetic matrix product model.
module tb_mat_mult_seq;

    typedef logic [17:0] mat_t [16];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start2 = 1'b0, start4 = 1'b0, clear = 1'b0;
    logic       mode_acc = 1'b0, signed_mode = 1'b0;
    logic [9:0] base_a = '0, base_b = '0, base_c = '0;
    logic       busy2, done2, busy4, done4;

    logic        gnt = 1'b1;
    bit          rand_gnt = 1'b0;
    logic [17:0] mem [0:1023];
    logic [17:0] rdata = '0;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [17:0] bd_data = '0;

    int cyc = 0, stall_cnt = 0, viol_cnt = 0;
    int n_checks = 0, n_pass = 0;

    logic        p_stall = 1'b0, p_abort = 1'b1, p_we = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [17:0] p_wd = '0;

    mat_mult_seq_if #(.ADDR_WIDTH(10), .ACC_SIZE(17)) if2 ();
    mat_mult_seq_if #(.ADDR_WIDTH(10), .ACC_SIZE(18)) if4 ();

    mat_mult_seq #(.DAT_SIZE(8), .MAT_SIZE(2), .ACC_SIZE(17), .ADDR_WIDTH(10)) u_n2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .clear(clear),
        .mode_acc(mode_acc), .signed_mode(signed_mode),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .busy(busy2), .done(done2), .mem(if2)
    );

    mat_mult_seq #(.DAT_SIZE(8), .MAT_SIZE(4), .ACC_SIZE(18), .ADDR_WIDTH(10)) u_n4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .clear(clear),
        .mode_acc(mode_acc), .signed_mode(signed_mode),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .busy(busy4), .done(done4), .mem(if4)
    );

    always #5 clk = ~clk;

    logic        a_req, a_we;
    logic [9:0]  a_addr;
    logic [17:0] a_wd;
    assign a_req  = if2.mem_req | if4.mem_req;
    assign a_we   = if4.mem_req ? if4.mem_we   : if2.mem_we;
    assign a_addr = if4.mem_req ? if4.mem_addr : if2.mem_addr;
    assign a_wd   = if4.mem_req ? if4.mem_wdata : {1'b0, if2.mem_wdata};

    assign if2.mem_gnt   = gnt;
    assign if4.mem_gnt   = gnt;
    assign if2.mem_rdata = rdata[16:0];
    assign if4.mem_rdata = rdata;

    // Memory, stall counter and request-stability monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_we) mem[bd_addr] <= bd_data;
        if (a_req && gnt) begin
            if (a_we) mem[a_addr] <= a_wd;
            else      rdata <= mem[a_addr];
        end
        if (p_stall && !p_abort && rst_n &&
            !(a_req && a_we == p_we && a_addr == p_addr && a_wd == p_wd))
            viol_cnt <= viol_cnt + 1;
        if (a_req && !gnt) stall_cnt <= stall_cnt + 1;
        p_stall <= a_req && !gnt;
        p_we    <= a_we;
        p_addr  <= a_addr;
        p_wd    <= a_wd;
        p_abort <= clear || !rst_n;
    end

    always @(negedge clk) gnt <= rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;

    function automatic longint opv(input logic [17:0] w, input bit sgn);
        logic [7:0] b8;
        b8 = w[7:0];
        if (sgn) return longint'($signed(b8));
        return longint'(b8);
    endfunction

    function automatic void ref_mult(input int n, input bit sgn, input bit acc,
                                     input mat_t a, input mat_t b, input mat_t c0,
                                     output mat_t r);
        longint s, mask;
        mask = (longint'(1) << (16 + $clog2(n))) - 1;
        r = '{default: '0};
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = acc ? longint'(c0[i*n+j]) : 0;
                for (int k = 0; k < n; k++)
                    s += opv(a[i*n+k], sgn) * opv(b[k*n+j], sgn);
                r[i*n+j] = 18'(s & mask);
            end
    endfunction

    task automatic poke(input logic [9:0] a, input logic [17:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic load_mat(input logic [9:0] base, input int n, input mat_t m);
        for (int idx = 0; idx < n*n; idx++) poke(10'(int'(base) + idx), m[idx]);
    endtask

    task automatic launch(input bit n4, output int t0);
        @(negedge clk);
        if (n4) start4 = 1'b1; else start2 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_done(input bit n4, input int t0, output int lat,
                             output int busy_cnt, output bit to);
        busy_cnt = 0;
        to = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (n4 ? done4 : done2) begin
                to = 1'b0;
                break;
            end
            if (n4 ? busy4 : busy2) busy_cnt++;
            @(negedge clk);
        end
        lat = cyc - t0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy2, done2, if2.mem_req, if2.mem_we, if2.mem_addr, if2.mem_wdata} !== '0)
            $display("FAIL reset_n2 got busy=%b done=%b req=%b we=%b addr=%0h wd=%0h exp all 0",
                     busy2, done2, if2.mem_req, if2.mem_we, if2.mem_addr, if2.mem_wdata);
        else n_pass++;
        n_checks++;
        if ({busy4, done4, if4.mem_req, if4.mem_we, if4.mem_addr, if4.mem_wdata} !== '0)
            $display("FAIL reset_n4 got busy=%b done=%b req=%b we=%b addr=%0h wd=%0h exp all 0",
                     busy4, done4, if4.mem_req, if4.mem_we, if4.mem_addr, if4.mem_wdata);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_n2();
        mat_t a = '{default: '0}, b = '{default: '0}, c0 = '{default: '0}, e;
        int t0, lat, bc;
        bit to;
        for (int idx = 0; idx < 4; idx++) begin
            a[idx] = 18'(idx + 1);
            b[idx] = 18'(idx + 5);
            c0[idx] = 18'h15555;
        end
        load_mat(10'h000, 2, a);
        load_mat(10'h010, 2, b);
        load_mat(10'h020, 2, c0);
        base_a = 10'h000; base_b = 10'h010; base_c = 10'h020;
        mode_acc = 1'b0; signed_mode = 1'b0;
        ref_mult(2, 1'b0, 1'b0, a, b, c0, e);
        launch(1'b0, t0);
        n_checks++;
        if (!(if2.mem_req === 1'b1 && if2.mem_we === 1'b0 && if2.mem_addr === 10'h000 && busy2 === 1'b1))
            $display("FAIL basic_first_req got req=%b we=%b addr=%0h busy=%b exp 1 0 0 1",
                     if2.mem_req, if2.mem_we, if2.mem_addr, busy2);
        else n_pass++;
        wait_done(1'b0, t0, lat, bc, to);
        n_checks++;
        if (to !== 1'b0 || lat !== 37) $display("FAIL basic_latency got %0d (timeout=%0b) exp 37", lat, to);
        else n_pass++;
        n_checks++;
        if (bc !== 36 || busy2 !== 1'b0) $display("FAIL basic_busy got cycles=%0d busy_at_done=%b exp 36 0", bc, busy2);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done2 !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done2);
        else n_pass++;
        for (int idx = 0; idx < 4; idx++) begin
            n_checks++;
            if (mem[10'(32 + idx)] !== e[idx])
                $display("FAIL basic_c[%0d] got %0h exp %0h", idx, mem[10'(32 + idx)], e[idx]);
            else n_pass++;
        end
    endtask

    task automatic test_signed_n2();
        mat_t a = '{default: '0}, b = '{default: '0}, c0 = '{default: '0}, e;
        int t0, lat, bc;
        bit to;
        a[0] = 18'h000FF; a[1] = 18'h00002; a[2] = 18'h00003; a[3] = 18'h000FC;
        b[0] = 18'd1; b[3] = 18'd1;
        load_mat(10'h030, 2, a);
        load_mat(10'h034, 2, b);
        base_a = 10'h030; base_b = 10'h034; base_c = 10'h038;
        mode_acc = 1'b0; signed_mode = 1'b1;
        ref_mult(2, 1'b1, 1'b0, a, b, c0, e);
        launch(1'b0, t0);
        wait_done(1'b0, t0, lat, bc, to);
        n_checks++;
        if (to !== 1'b0 || lat !== 37) $display("FAIL signed_latency got %0d exp 37", lat);
        else n_pass++;
        for (int idx = 0; idx < 4; idx++) begin
            n_checks++;
            if (mem[10'(56 + idx)] !== e[idx])
                $display("FAIL signed_c[%0d] got %0h exp %0h", idx, mem[10'(56 + idx)], e[idx]);
            else n_pass++;
        end
    endtask

    task automatic test_acc_n2();
        mat_t a = '{default: '0}, c0 = '{default: '0}, e;
        int t0, lat, bc;
        bit to;
        a[0] = 18'd1; a[3] = 18'd1;
        load_mat(10'h040, 2, a);
        base_a = 10'h040; base_b = 10'h040; base_c = 10'h048;
        mode_acc = 1'b1; signed_mode = 1'b0;
        for (int run = 0; run < 2; run++) begin
            for (int idx = 0; idx < 4; idx++) c0[idx] = (run == 0) ? 18'd10 : 18'h1FFFF;
            load_mat(10'h048, 2, c0);
            ref_mult(2, 1'b0, 1'b1, a, a, c0, e);
            launch(1'b0, t0);
            wait_done(1'b0, t0, lat, bc, to);
            n_checks++;
            if (to !== 1'b0 || lat !== 45) $display("FAIL acc_latency run%0d got %0d exp 45", run, lat);
            else n_pass++;
            for (int idx = 0; idx < 4; idx++) begin
                n_checks++;
                if (mem[10'(72 + idx)] !== e[idx])
                    $display("FAIL acc_c run%0d [%0d] got %0h exp %0h", run, idx, mem[10'(72 + idx)], e[idx]);
                else n_pass++;
            end
        end
        mode_acc = 1'b0;
    endtask

    task automatic test_start_ignored();
        mat_t a = '{default: '0}, b = '{default: '0}, c0 = '{default: '0}, e;
        int t0, lat, bc;
        bit to;
        for (int idx = 0; idx < 4; idx++) begin
            a[idx] = 18'($urandom_range(0, 255));
            b[idx] = 18'($urandom_range(0, 255));
            c0[idx] = 18'h0AAAA;
        end
        load_mat(10'h050, 2, a);
        load_mat(10'h054, 2, b);
        load_mat(10'h060, 2, c0);
        load_mat(10'h080, 2, c0);
        base_a = 10'h050; base_b = 10'h054; base_c = 10'h060;
        mode_acc = 1'b0; signed_mode = 1'b0;
        ref_mult(2, 1'b0, 1'b0, a, b, c0, e);
        launch(1'b0, t0);
        repeat (5) @(negedge clk);
        base_a = 10'h090; base_c = 10'h080; mode_acc = 1'b1; signed_mode = 1'b1;
        start2 = 1'b1;
        repeat (2) @(negedge clk);
        start2 = 1'b0;
        wait_done(1'b0, t0, lat, bc, to);
        n_checks++;
        if (to !== 1'b0 || lat !== 37) $display("FAIL ignore_latency got %0d exp 37", lat);
        else n_pass++;
        for (int idx = 0; idx < 4; idx++) begin
            n_checks++;
            if (mem[10'(96 + idx)] !== e[idx])
                $display("FAIL ignore_c[%0d] got %0h exp %0h", idx, mem[10'(96 + idx)], e[idx]);
            else n_pass++;
            n_checks++;
            if (mem[10'(128 + idx)] !== 18'h0AAAA)
                $display("FAIL ignore_alt[%0d] got %0h exp 0aaaa", idx, mem[10'(128 + idx)]);
            else n_pass++;
        end
        mode_acc = 1'b0; signed_mode = 1'b0;
    endtask

    task automatic test_clear();
        mat_t a = '{default: '0}, b = '{default: '0}, c0 = '{default: '0}, e;
        int t0, lat, bc;
        bit to, seen;
        for (int idx = 0; idx < 16; idx++) begin
            a[idx] = 18'($urandom_range(0, 255));
            b[idx] = 18'($urandom_range(0, 255));
            c0[idx] = 18'h2AAAA;
        end
        load_mat(10'h200, 4, a);
        load_mat(10'h220, 4, b);
        load_mat(10'h240, 4, c0);
        base_a = 10'h200; base_b = 10'h220; base_c = 10'h240;
        mode_acc = 1'b0; signed_mode = 1'b0;
        ref_mult(4, 1'b0, 1'b0, a, b, c0, e);
        launch(1'b1, t0);
        // Cycle T+76 is WT_B of element (1,0), k=1.
        while (cyc < t0 + 76) @(negedge clk);
        n_checks++;
        if (if4.mem_req !== 1'b0 || busy4 !== 1'b1)
            $display("FAIL clear_pre got req=%b busy=%b exp 0 1", if4.mem_req, busy4);
        else n_pass++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if ({if4.mem_req, busy4, done4} !== 3'b000)
            $display("FAIL clear_next got req=%b busy=%b done=%b exp 000", if4.mem_req, busy4, done4);
        else n_pass++;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done4 || busy4) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL clear_quiet got activity=%b exp 0", seen);
        else n_pass++;
        for (int idx = 0; idx < 16; idx++) begin
            n_checks++;
            if (mem[10'(576 + idx)] !== ((idx < 4) ? e[idx] : c0[idx]))
                $display("FAIL clear_partial[%0d] got %0h exp %0h", idx, mem[10'(576 + idx)],
                         (idx < 4) ? e[idx] : c0[idx]);
            else n_pass++;
        end
        launch(1'b1, t0);
        wait_done(1'b1, t0, lat, bc, to);
        n_checks++;
        if (to !== 1'b0 || lat !== 273) $display("FAIL clear_rerun_latency got %0d exp 273", lat);
        else n_pass++;
        for (int idx = 0; idx < 16; idx++) begin
            n_checks++;
            if (mem[10'(576 + idx)] !== e[idx])
                $display("FAIL clear_rerun_c[%0d] got %0h exp %0h", idx, mem[10'(576 + idx)], e[idx]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit seen;
        launch(1'b1, t0);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy4, done4, if4.mem_req, if4.mem_we, if4.mem_addr, if4.mem_wdata} !== '0)
            $display("FAIL reset_mid got busy=%b done=%b req=%b we=%b addr=%0h wd=%0h exp all 0",
                     busy4, done4, if4.mem_req, if4.mem_we, if4.mem_addr, if4.mem_wdata);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done4 || busy4) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL reset_mid_quiet got activity=%b exp 0", seen);
        else n_pass++;
    endtask

    task automatic test_random_stall();
        mat_t a = '{default: '0}, b = '{default: '0}, c0 = '{default: '0}, e;
        int t0, lat, bc, s0, v0, nominal;
        bit to;
        rand_gnt = 1'b1;
        for (int run = 0; run < 2; run++) begin
            for (int idx = 0; idx < 16; idx++) begin
                a[idx] = 18'($urandom);
                b[idx] = 18'($urandom);
                c0[idx] = (run == 0) ? 18'h15A5A : 18'($urandom);
            end
            load_mat(10'h100, 4, a);
            load_mat(10'h120, 4, b);
            load_mat(10'h140, 4, c0);
            base_a = 10'h100; base_b = 10'h120; base_c = 10'h140;
            mode_acc = (run == 1); signed_mode = (run == 1);
            nominal = (run == 1) ? 305 : 273;
            ref_mult(4, run == 1, run == 1, a, b, c0, e);
            s0 = stall_cnt;
            v0 = viol_cnt;
            launch(1'b1, t0);
            wait_done(1'b1, t0, lat, bc, to);
            n_checks++;
            if (to !== 1'b0 || lat !== nominal + (stall_cnt - s0))
                $display("FAIL stall_latency run%0d got %0d exp %0d", run, lat, nominal + (stall_cnt - s0));
            else n_pass++;
            n_checks++;
            if (viol_cnt - v0 !== 0)
                $display("FAIL stall_stability run%0d got %0d violations exp 0", run, viol_cnt - v0);
            else n_pass++;
            for (int idx = 0; idx < 16; idx++) begin
                n_checks++;
                if (mem[10'(320 + idx)] !== e[idx])
                    $display("FAIL stall_c run%0d [%0d] got %0h exp %0h", run, idx, mem[10'(320 + idx)], e[idx]);
                else n_pass++;
            end
        end
        rand_gnt = 1'b0;
        mode_acc = 1'b0; signed_mode = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_n2();
        test_signed_n2();
        test_acc_n2();
        test_start_ignored();
        test_clear();
        test_reset_mid();
        test_random_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion exp finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
